exe_muldiv: RTL and testbench
=============================

EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock shared with all pipeline registers.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  EXE stage holds a MULT/MULTU/DIV/DIVU; sampled only in IDLE.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-006 src_a  input  32  forwarded rs value (dividend / multiplicand).
REQ-007 src_b  input  32  forwarded rt value (divisor / multiplier).
REQ-008 flush  input  1  EXE flush (exception or branch kill); cancels any operation.
REQ-009 busy  output  1  stall request to PC, IF_ID and ID_EXE write enables.
REQ-010 done  output  1  one-cycle pulse; hi_out/lo_out hold a new result and are to be written to HI/LO.
REQ-011 hi_out  output  32  high product word or remainder.
REQ-012 lo_out  output  32  low product word or quotient.

Function
REQ-013 The block SHALL implement states IDLE, MUL, DIV and DONE.
REQ-014 IDLE, start=1, flush=0 -> MUL if op[1]=0, else DIV; the operands and op SHALL be captured in that cycle.
REQ-015 In IDLE, busy SHALL equal start & ~flush (combinational), so the issuing instruction stalls in its own cycle.
REQ-016 In MUL and DIV, busy SHALL be 1; in DONE, busy SHALL be 0, so the pipeline advances in the DONE cycle.
REQ-017 MUL lasts exactly 1 cycle and then goes to DONE; a start in cycle N SHALL give done in cycle N+2.
REQ-018 MULT SHALL produce the signed 64-bit product; MULTU SHALL produce the unsigned product; {hi_out,lo_out} = product.
REQ-019 DIV SHALL be a radix-2 restoring divide on operand magnitudes, with a 6-bit iteration counter running 0..31.
REQ-020 DIV lasts exactly 32 cycles and then goes to DONE; a start in cycle N SHALL give done in cycle N+33.
REQ-021 For DIV, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-022 For DIVU, the operands SHALL be treated as unsigned.
REQ-023 Divisor=0 SHALL raise no exception and SHALL take the normal latency, with lo_out=0xFFFFFFFF and hi_out=src_a for DIVU.
REQ-024 For DIV with divisor=0, lo_out SHALL be 0xFFFFFFFF if src_a>=0, else 0x00000001, and hi_out SHALL be src_a.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo_out=0x80000000 and hi_out=0, with no trap.
REQ-026 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-027 hi_out/lo_out SHALL hold their value until the next DONE and SHALL change only on entry to DONE.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 A back-to-back start in the cycle after DONE SHALL be accepted normally.
REQ-030 flush=1 in any state SHALL force IDLE next cycle with no done pulse, and hi_out/lo_out SHALL remain unchanged.
REQ-031 When start and flush are both 1 in IDLE, flush SHALL win: nothing is captured and busy=0.
REQ-032 flush in the DONE cycle SHALL suppress done to 0, and the result registers SHALL not update.
REQ-033 No output SHALL depend combinationally on src_a or src_b.

Reset
REQ-034 rst=1 SHALL give state IDLE, counter 0, busy 0, done 0, and hi_out=lo_out=0x00000000 on the next edge.
REQ-035 rst mid-operation SHALL abort the operation with no done pulse and outputs cleared.
REQ-036 rst SHALL take priority over flush and start.

Verification
REQ-037 MULT 0xFFFFFFFE x 0x00000003, start at cycle 0 -> busy=1 in cycles 0-1, done in cycle 2, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-038 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done in cycle 2.
REQ-039 DIV 0xFFFFFFF9 (-7) / 2 -> done in cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy high in cycles 0-32.
REQ-040 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100, done in cycle 33, no other side effect.
REQ-041 DIVU started with flush asserted in cycle 10 -> IDLE in cycle 11, no done, hi/lo keep their prior values; a new MULT in cycle 12 completes in cycle 14.
REQ-042 rst in cycle 5 of a DIV -> cycle 6: busy=0, done=0, hi=lo=0; start held high while busy is ignored.

Source files
------------

// File: rtl/exe_muldiv_if.sv
// Handshake and result bundle between the EXE stage and the HI/LO multiply/divide unit.
// The EXE stage uses the master view and the unit uses the slave view.
interface exe_muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, hi_out, lo_out
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/exe_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the EXE stage.
// Multiplies take one cycle and divides take 32 restoring iterations; the result is presented with a one-cycle done pulse.
module exe_muldiv (
    input  logic        clk,
    input  logic        rst,
    exe_muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'd31;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
        if (neg) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

    state_t      r_state;
    state_t      w_state_next;

    logic        r_mul_signed;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_busy;
    logic        w_done;
    logic        w_op_signed;
    logic        w_last_iter;
    logic        w_load_mul;
    logic        w_load_div;
    logic        w_fits;
    logic [32:0] w_mul_a;
    logic [32:0] w_mul_b;
    logic [63:0] w_prod;
    logic [32:0] w_shift;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;

    assign w_op_signed = ~bus.op[0];
    assign w_accept    = (r_state == S_IDLE) & bus.start & ~bus.flush & ~rst;
    assign w_last_iter = (r_cnt == LAST_ITER);
    assign w_load_mul  = (r_state == S_MUL) & ~bus.flush;
    assign w_load_div  = (r_state == S_DIV) & ~bus.flush & w_last_iter;

    // Extending by one bit lets the same signed multiplier serve MULT and MULTU.
    assign w_mul_a = {r_mul_signed & r_mul_a[31], r_mul_a};
    assign w_mul_b = {r_mul_signed & r_mul_b[31], r_mul_b};
    assign w_prod  = 64'($signed(w_mul_a)) * 64'($signed(w_mul_b));

    // One restoring step: the partial remainder is always below the divisor, so 32 bits hold it.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_fits     = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_fits ? (w_shift[31:0] - r_dvs) : w_shift[31:0];
    assign w_quo_next = {r_quo[30:0], w_fits};

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.hi_out = r_hi;
    assign bus.lo_out = r_lo;

    // Next-state, stall request and done pulse.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = w_accept;
                if (w_accept) begin
                    if (bus.op[1]) begin
                        w_state_next = S_DIV;
                    end else begin
                        w_state_next = S_MUL;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_MUL: begin
                w_busy = 1'b1;
                if (bus.flush) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_DIV: begin
                w_busy = 1'b1;
                if (bus.flush) begin
                    w_state_next = S_IDLE;
                end else if (w_last_iter) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_DIV;
                end
            end
            S_DONE: begin
                w_done       = ~bus.flush;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture and divider iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_signed <= 1'b0;
            r_mul_a      <= 32'd0;
            r_mul_b      <= 32'd0;
            r_quo        <= 32'd0;
            r_rem        <= 32'd0;
            r_dvs        <= 32'd0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_cnt        <= 6'd0;
        end else if (w_accept) begin
            r_mul_signed <= w_op_signed;
            r_mul_a      <= bus.src_a;
            r_mul_b      <= bus.src_b;
            r_quo        <= magnitude(bus.src_a, w_op_signed);
            r_dvs        <= magnitude(bus.src_b, w_op_signed);
            r_rem        <= 32'd0;
            r_neg_q      <= w_op_signed & (bus.src_a[31] ^ bus.src_b[31]);
            r_neg_r      <= w_op_signed & bus.src_a[31];
            r_cnt        <= 6'd0;
        end else if ((r_state == S_DIV) && !bus.flush) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            if (w_last_iter) begin
                r_cnt <= 6'd0;
            end else begin
                r_cnt <= r_cnt + 6'd1;
            end
        end else begin
            r_cnt <= 6'd0;
        end
    end

    // Result registers load only on the transition into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_load_mul) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
        end else if (w_load_div) begin
            r_hi <= apply_sign(w_rem_next, r_neg_r);
            r_lo <= apply_sign(w_quo_next, r_neg_q);
        end else begin
            r_hi <= r_hi;
            r_lo <= r_lo;
        end
    end
endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed corner vectors, flush/reset scenarios
// and randomized operations compared against a plain-arithmetic reference model.
module tb_exe_muldiv;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    exe_muldiv_if bus ();

    exe_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  lat;
    } vec_t;

    // Reference result {hi, lo} computed with native SV arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        longint      p;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) begin
                    q = a[31] ? 32'd1 : 32'hFFFFFFFF;
                    return {a, q};
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    return {32'd0, 32'h80000000};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r, q};
                end
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                else return {a % b, a / b};
            end
        endcase
    endfunction

    // Issues one operation at the next cycle, holds start while busy and scrambles operands
    // after issue; reports latency (-1 on timeout), result and busy-profile errors.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] hi, output logic [31:0] lo, output int busy_err);
        lat = -1;
        busy_err = 0;
        hi = 32'd0;
        lo = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                hi  = bus.hi_out;
                lo  = bus.lo_out;
                if (bus.busy !== 1'b0) busy_err++;
                break;
            end
            if (bus.busy !== 1'b1) busy_err++;
            @(posedge clk); #1;
            bus.src_a = $urandom;
            bus.src_b = $urandom;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op = 2'b00;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.src_a = 32'd5;
        bus.src_b = 32'd6;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        n_tests++;
        if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_result hi=%h lo=%h want 0 0", bus.hi_out, bus.lo_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_vectors();
        vec_t        vecs [8];
        int          lat;
        int          berr;
        logic [31:0] hi;
        logic [31:0] lo;
        vecs = '{
            '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 8'd2},
            '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 8'd2},
            '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 8'd33},
            '{2'b11, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF, 8'd33},
            '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 8'd33},
            '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001, 8'd33},
            '{2'b10, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 8'd33},
            '{2'b10, 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000001, 8'd33}
        };
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, hi, lo, berr);
            n_tests++;
            if (lat !== int'(vecs[i].lat)) begin
                n_fail++;
                $display("FAIL vec%0d latency got %0d want %0d", i, lat, vecs[i].lat);
            end
            n_tests++;
            if (hi !== vecs[i].hi || lo !== vecs[i].lo) begin
                n_fail++;
                $display("FAIL vec%0d result got hi=%h lo=%h want hi=%h lo=%h", i, hi, lo, vecs[i].hi, vecs[i].lo);
            end
            n_tests++;
            if (berr !== 0) begin
                n_fail++;
                $display("FAIL vec%0d busy_profile got %0d bad cycles want 0", i, berr);
            end
        end
    endtask

    task automatic test_flush_div();
        int          lat;
        int          berr;
        int          seen_done;
        logic [31:0] hi;
        logic [31:0] lo;
        do_op(2'b01, 32'd3, 32'd5, lat, hi, lo, berr);
        seen_done = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.src_a = $urandom;
        bus.src_b = 32'd7;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done++;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        if (bus.done !== 1'b0) seen_done++;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || seen_done != 0) begin
            n_fail++;
            $display("FAIL flush_div_idle busy=%b done=%b stray_done=%0d want 0 0 0", bus.busy, bus.done, seen_done);
        end
        n_tests++;
        if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd15) begin
            n_fail++;
            $display("FAIL flush_div_hold hi=%h lo=%h want 0 f", bus.hi_out, bus.lo_out);
        end
        do_op(2'b00, 32'hFFFFFFFD, 32'd4, lat, hi, lo, berr);
        n_tests++;
        if (lat !== 2 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF4) begin
            n_fail++;
            $display("FAIL flush_div_next_mult lat=%0d hi=%h lo=%h want 2 ffffffff fffffff4", lat, hi, lo);
        end
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done++;
        end
        n_tests++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL flush_div_no_late_done got %0d pulses want 0", seen_done);
        end
    endtask

    task automatic test_flush_mul_and_done();
        int          lat;
        int          berr;
        int          seen_done;
        logic [31:0] hi;
        logic [31:0] lo;
        do_op(2'b00, 32'd2, 32'd3, lat, hi, lo, berr);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done++;
        end
        n_tests++;
        if (seen_done != 0 || bus.hi_out !== 32'd0 || bus.lo_out !== 32'd6) begin
            n_fail++;
            $display("FAIL flush_mul stray_done=%0d hi=%h lo=%h want 0 0 6", seen_done, bus.hi_out, bus.lo_out);
        end
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.src_a = 32'd9;
        bus.src_b = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_in_done done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_in_done_after done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
        do_op(2'b11, 32'd50, 32'd7, lat, hi, lo, berr);
        n_tests++;
        if (lat !== 33 || hi !== 32'd1 || lo !== 32'd7) begin
            n_fail++;
            $display("FAIL flush_in_done_next lat=%0d hi=%h lo=%h want 33 1 7", lat, hi, lo);
        end
    endtask

    task automatic test_start_flush_idle();
        int          seen_done;
        int          seen_busy;
        logic [31:0] hi_prev;
        logic [31:0] lo_prev;
        hi_prev = bus.hi_out;
        lo_prev = bus.lo_out;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 2'b00;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_flush_busy got %b want 0", bus.busy);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        seen_done = 0;
        seen_busy = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done++;
            if (bus.busy !== 1'b0) seen_busy++;
        end
        n_tests++;
        if (seen_done != 0 || seen_busy != 0 || bus.hi_out !== hi_prev || bus.lo_out !== lo_prev) begin
            n_fail++;
            $display("FAIL start_flush_nocapture done=%0d busy=%0d hi=%h lo=%h want 0 0 %h %h",
                     seen_done, seen_busy, bus.hi_out, bus.lo_out, hi_prev, lo_prev);
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        int          berr;
        int          seen_done;
        logic [31:0] hi;
        logic [31:0] lo;
        do_op(2'b01, 32'd7, 32'd9, lat, hi, lo, berr);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        berr = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) berr++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (berr != 0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid busy_err=%0d busy=%b done=%b hi=%h lo=%h want 0 0 0 0 0",
                     berr, bus.busy, bus.done, bus.hi_out, bus.lo_out);
        end
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done++;
        end
        n_tests++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done got %0d pulses want 0", seen_done);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          berr;
        logic [31:0] hi;
        logic [31:0] lo;
        do_op(2'b10, 32'hFFFFFF9C, 32'd7, lat, hi, lo, berr);
        n_tests++;
        if (lat !== 33 || hi !== 32'hFFFFFFFE || lo !== 32'hFFFFFFF2) begin
            n_fail++;
            $display("FAIL b2b_first lat=%0d hi=%h lo=%h want 33 fffffffe fffffff2", lat, hi, lo);
        end
        do_op(2'b00, 32'h80000000, 32'h80000000, lat, hi, lo, berr);
        n_tests++;
        if (lat !== 2 || hi !== 32'h40000000 || lo !== 32'h00000000 || berr != 0) begin
            n_fail++;
            $display("FAIL b2b_second lat=%0d hi=%h lo=%h busy_err=%0d want 2 40000000 0 0", lat, hi, lo, berr);
        end
    endtask

    task automatic test_random();
        int          lat;
        int          berr;
        int          sel;
        int          gap;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] exp;
        for (int i = 0; i < 60; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                4: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            exp = ref_result(op, a, b);
            do_op(op, a, b, lat, hi, lo, berr);
            n_tests++;
            if (lat !== (op[1] ? 33 : 2) || berr != 0) begin
                n_fail++;
                $display("FAIL rand%0d timing op=%0d lat=%0d busy_err=%0d", i, op, lat, berr);
            end
            n_tests++;
            if ({hi, lo} !== exp) begin
                n_fail++;
                $display("FAIL rand%0d result op=%0d a=%h b=%h got %h_%h want %h", i, op, a, b, hi, lo, exp);
            end
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
                @(negedge clk);
                n_tests++;
                if (bus.done !== 1'b0 || {bus.hi_out, bus.lo_out} !== exp) begin
                    n_fail++;
                    $display("FAIL rand%0d hold done=%b got %h_%h want %h", i, bus.done, bus.hi_out, bus.lo_out, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_flush_div();
        test_flush_mul_and_done();
        test_start_flush_idle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
